frame_pattern_check: RTL and testbench
======================================

// Module: frame_pattern_check
// PURPOSE
//  Consumes fval/lval/pixel stream produced by frame-buffer read-back stage (FIFO-drain side).
//  Checks frame geometry (pixels per line, lines per frame) and incrementing test pattern.
//  Reports per-frame result plus running counters. Sits at end of mcb test datapath.
// PARAMETERS
//  DATA_WIDTH  8    pixel width, bits
//  H_PIX       64   expected pixels per line
//  V_LINE      32   expected lines per frame
//  CNT_WIDTH   16   width of frame/error counters
// PORTS
//  clk            in   1            single clock
//  reset          in   1            synchronous, active-high
//  i_fval         in   1            frame valid
//  i_lval         in   1            pixel valid (line valid, qualified per pixel)
//  iv_pix_data    in   DATA_WIDTH   pixel data, valid when i_lval=1
//  o_frame_done   out  1            1-cycle pulse after each checked frame
//  o_frame_ok     out  1            result of last frame, valid from o_frame_done, held
//  ov_frame_cnt   out  CNT_WIDTH    frames checked, wraps
//  ov_err_cnt     out  CNT_WIDTH    frames failed, saturates at all-ones
//  ov_line_last   out  16           line count of last frame
// BEHAVIOUR
//  Reset: all outputs 0; FSM->S_SYNC; internal counters 0.
//  FSM:
//   S_SYNC   : ignore input until i_fval=0, then ->S_IDLE (avoids checking partial frame after reset).
//   S_IDLE   : i_fval rising (registered fval 0->1) ->S_ACTIVE; clear line/pix counters; seed=ov_frame_cnt[DATA_WIDTH-1:0].
//   S_ACTIVE : on each i_lval=1 cycle: compare iv_pix_data with exp, exp<=exp+1 (mod 2^DATA_WIDTH), pix_cnt++.
//              Line ends when i_lval=0 and pix_cnt!=0: pix_cnt!=H_PIX -> geo_err; line_cnt++; pix_cnt<=0.
//              i_lval may drop mid-line only as gap; a line is closed only when fval falls or a gap follows
//              exactly H_PIX pixels (rule: line closes when pix_cnt reaches H_PIX, or at fval fall if pix_cnt!=0).
//              i_fval falling ->S_REPORT; pending partial line closed with geo_err.
//   S_REPORT : one cycle: o_frame_done=1; o_frame_ok=!(geo_err|pix_err|line_cnt!=V_LINE);
//              ov_frame_cnt++; ov_err_cnt++ if fail (saturating); ov_line_last<=line_cnt; ->S_IDLE.
//  exp initial value = seed, so frame N expects first pixel N mod 2^DATA_WIDTH.
//  i_lval=1 while i_fval=0 -> protocol error: flagged into next frame's result (fail), not counted as pixels.
//  i_fval rising in same cycle S_REPORT executes: captured, next frame starts normally (no lost frame).
//  Latency: o_frame_done 2 cycles after i_fval falling edge at input.
//  pix_cnt/line_cnt saturate at 16'hFFFF; no wrap-around false pass.
//  Reset mid-frame: abandon frame, no o_frame_done, return to S_SYNC.
// CONFIGURATION
//  PATTERN_CHECK_EN defined  : pixel value compare active; mismatch sets pix_err.
//  PATTERN_CHECK_EN undefined: compare logic and exp register removed; pix_err tied 0;
//                              only geometry and protocol checked.
// STRUCTURE
//  Shared include frame_check_def.vh: FSM state encodings (S_SYNC/S_IDLE/S_ACTIVE/S_REPORT, 2 bits),
//  counter width constants.
//  One sub-module: fval_edge_det (registers fval, outputs rise/fall pulses); used for i_fval.
// TESTING
//  1 reset, 3 frames 32 lines x 64 px, pattern seeded 0,1,2 -> 3 done pulses, ok=1, frame_cnt=3, err_cnt=0, line_last=32.
//  2 frame with line 5 of 63 px -> o_frame_ok=0, err_cnt=1; next good frame -> ok=1, err_cnt stays 1.
//  3 frame with pixel 100 corrupted (xor 8'h01) -> ok=0 with PATTERN_CHECK_EN; ok=1 without it.
//  4 reset released mid-frame (fval=1) -> that frame ignored, no pulse; next full frame ok=1, frame_cnt=1.
//  5 frame of 31 lines -> ok=0, line_last=31; lval=1 pulse with fval=0 -> following frame ok=0.
//  6 fval back-to-back (fall, rise next cycle), random lval gaps (FIFO empty stalls) -> all frames ok=1.

Source files
------------

// File: rtl/frame_pattern_check_pkg.sv
// Shared definitions for the frame pattern checker: FSM encoding, geometry counter width,
// and the saturating increment used by the pixel and line counters.
package frame_pattern_check_pkg;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_REPORT = 2'd3
  } state_e;

  localparam int GEO_W = 16;

  function automatic logic [GEO_W-1:0] sat_inc16(input logic [GEO_W-1:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_pattern_check_fval_edge_det.sv
// Registers frame-valid and produces rise/fall pulses relative to the registered copy,
// so an edge is reported in the same cycle the new level is seen at the input.
module frame_pattern_check_fval_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic fval_i,
  output logic rise_o,
  output logic fall_o
);

  logic fval_q;

  always_ff @(posedge clk) begin
    if (reset) fval_q <= 1'b0;
    else       fval_q <= fval_i;
  end

  assign rise_o = fval_i & ~fval_q;
  assign fall_o = ~fval_i & fval_q;

endmodule

// File: rtl/frame_pattern_check.sv
// Frame geometry and incrementing-pattern checker for the frame-buffer read-back stream.
// Build option PATTERN_CHECK_EN: when defined, pixel values are compared against the expected ramp.
module frame_pattern_check
  import frame_pattern_check_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_PIX      = 64,
  parameter int V_LINE     = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_fval,
  input  logic                  i_lval,
  input  logic [DATA_WIDTH-1:0] iv_pix_data,
  output logic                  o_frame_done,
  output logic                  o_frame_ok,
  output logic [CNT_WIDTH-1:0]  ov_frame_cnt,
  output logic [CNT_WIDTH-1:0]  ov_err_cnt,
  output logic [GEO_W-1:0]      ov_line_last,
  output logic [1:0]            o_dbg_state
);

  // Stream: a pixel is taken on every cycle with i_fval & i_lval; there is no backpressure.
  state_e               state_q;
  logic [GEO_W-1:0]     pix_cnt_q, line_cnt_q, line_last_q;
  logic                 geo_err_q, pix_err_q, prot_pend_q, frame_prot_q;
  logic                 done_q, ok_q;
  logic [CNT_WIDTH-1:0] frame_cnt_q, err_cnt_q;

  logic             fval_rise, fval_fall;
  logic             in_frame, frame_start, pix_accept, line_end, pix_bad, frame_fail;
  logic [GEO_W-1:0] pix_base, line_base, pix_inc;

  frame_pattern_check_fval_edge_det u_fval_edge (
    .clk   (clk),
    .reset (reset),
    .fval_i(i_fval),
    .rise_o(fval_rise),
    .fall_o(fval_fall)
  );

  // A rise seen during S_REPORT starts the next frame directly (back-to-back frames).
  always_comb begin
    in_frame    = (state_q == S_ACTIVE);
    frame_start = fval_rise & ((state_q == S_IDLE) | (state_q == S_REPORT));
    pix_accept  = i_fval & i_lval & (in_frame | frame_start);
    pix_base    = in_frame ? pix_cnt_q : '0;
    line_base   = in_frame ? line_cnt_q : '0;
    pix_inc     = sat_inc16(pix_base);
    line_end    = (pix_inc == GEO_W'(H_PIX));
    frame_fail  = geo_err_q | pix_err_q | frame_prot_q | (line_cnt_q != GEO_W'(V_LINE));
  end

`ifdef PATTERN_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_q, seed, exp_base;

  // Seed follows the frame counter; in S_REPORT the counter is about to step.
  always_comb begin
    seed = frame_cnt_q[DATA_WIDTH-1:0];
    if (state_q == S_REPORT) seed = seed + DATA_WIDTH'(1);
    exp_base = in_frame ? exp_q : seed;
    pix_bad  = pix_accept & (iv_pix_data != exp_base);
  end

  always_ff @(posedge clk) begin
    if (reset)            exp_q <= '0;
    else if (pix_accept)  exp_q <= exp_base + DATA_WIDTH'(1);
    else if (frame_start) exp_q <= seed;
  end
`else
  logic unused_pix;
  assign unused_pix = ^iv_pix_data;
  assign pix_bad    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_SYNC;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_last_q  <= '0;
      geo_err_q    <= 1'b0;
      pix_err_q    <= 1'b0;
      prot_pend_q  <= 1'b0;
      frame_prot_q <= 1'b0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_lval & ~i_fval & (state_q != S_SYNC)) prot_pend_q <= 1'b1;
      case (state_q)
        S_SYNC: if (!i_fval) state_q <= S_IDLE;
        S_IDLE: state_q <= S_IDLE;
        S_ACTIVE: begin
          if (fval_fall) begin
            if (pix_cnt_q != '0) begin
              geo_err_q  <= 1'b1;
              line_cnt_q <= sat_inc16(line_cnt_q);
              pix_cnt_q  <= '0;
            end
            state_q <= S_REPORT;
          end
        end
        S_REPORT: begin
          done_q      <= 1'b1;
          ok_q        <= ~frame_fail;
          frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
          if (frame_fail && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
          line_last_q <= line_cnt_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_SYNC;
      endcase
      if (frame_start) begin
        state_q      <= S_ACTIVE;
        pix_cnt_q    <= '0;
        line_cnt_q   <= '0;
        geo_err_q    <= 1'b0;
        pix_err_q    <= 1'b0;
        frame_prot_q <= prot_pend_q;
        prot_pend_q  <= 1'b0;
      end
      // Lines close on pixel count alone, so lval gaps inside a line are harmless.
      if (pix_accept) begin
        if (line_end) begin
          pix_cnt_q  <= '0;
          line_cnt_q <= sat_inc16(line_base);
        end else begin
          pix_cnt_q <= pix_inc;
        end
        if (pix_bad) pix_err_q <= 1'b1;
      end
    end
  end

  assign o_frame_done = done_q;
  assign o_frame_ok   = ok_q;
  assign ov_frame_cnt = frame_cnt_q;
  assign ov_err_cnt   = err_cnt_q;
  assign ov_line_last = line_last_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_frame_pattern_check.sv
// Directed bench for frame_pattern_check: geometry, pattern, protocol, reset and back-to-back frames.
// Expectations for the corrupted-pixel frame follow PATTERN_CHECK_EN.
module tb_frame_pattern_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_fval, i_lval;
  logic [7:0]  iv_pix_data;
  logic        o_frame_done, o_frame_ok;
  logic [15:0] ov_frame_cnt, ov_err_cnt, ov_line_last;
  logic [1:0]  o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int bad_seen = 0;
  int done_ref, bad_ref;
  int exp_err;
  logic exp_ok;

  always #5 clk = ~clk;

  frame_pattern_check dut (
    .clk         (clk),
    .reset       (reset),
    .i_fval      (i_fval),
    .i_lval      (i_lval),
    .iv_pix_data (iv_pix_data),
    .o_frame_done(o_frame_done),
    .o_frame_ok  (o_frame_ok),
    .ov_frame_cnt(ov_frame_cnt),
    .ov_err_cnt  (ov_err_cnt),
    .ov_line_last(ov_line_last),
    .o_dbg_state (o_dbg_state)
  );

  always @(negedge clk) begin
    if (o_frame_done) begin
      done_seen++;
      if (!o_frame_ok) bad_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic f, input logic l, input logic [7:0] d);
    @(negedge clk);
    i_fval      = f;
    i_lval      = l;
    iv_pix_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  // One frame: a lead cycle with fval only, lines of 64 px (63 on short_line), a blank after each line.
  task automatic send_frame(input int n_lines, input int short_line, input int seed,
                            input int corrupt_idx, input int gap_max, input int tail);
    int idx = 0;
    int npx;
    logic [7:0] d;
    drive(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < n_lines; l++) begin
      npx = (l == short_line) ? 63 : 64;
      for (int p = 0; p < npx; p++) begin
        if (gap_max > 0 && $urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, gap_max)) drive(1'b1, 1'b0, 8'h00);
        d = 8'(seed + idx);
        if (idx == corrupt_idx) d = d ^ 8'h01;
        drive(1'b1, 1'b1, d);
        idx++;
      end
      drive(1'b1, 1'b0, 8'h00);
    end
    for (int t = 0; t < tail; t++) drive(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; i_fval = 1'b0; i_lval = 1'b0; iv_pix_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_done",   o_frame_done, 0);
    check("rst_ok",     o_frame_ok, 0);
    check("rst_fcnt",   ov_frame_cnt, 0);
    check("rst_ecnt",   ov_err_cnt, 0);
    check("rst_llast",  ov_line_last, 0);
    check("rst_state",  o_dbg_state, 0);
    @(negedge clk) reset = 1'b0;
    idle(3);

    // Three good frames seeded 0,1,2; latency checked on the first.
    send_frame(32, -1, 0, -1, 0, 1);
    @(negedge clk); #1 check("lat_c1", o_frame_done, 0);
    @(negedge clk); #1 check("lat_c2", o_frame_done, 1);
    check("f1_ok", o_frame_ok, 1);
    @(negedge clk); #1 check("lat_c3", o_frame_done, 0);
    idle(2);
    send_frame(32, -1, 1, -1, 0, 4);
    send_frame(32, -1, 2, -1, 0, 4);
    #1;
    check("t1_done", done_seen, 3);
    check("t1_ok",   o_frame_ok, 1);
    check("t1_fcnt", ov_frame_cnt, 3);
    check("t1_ecnt", ov_err_cnt, 0);
    check("t1_llast", ov_line_last, 32);

    // Line 5 short by one pixel, then a good frame.
    send_frame(32, 5, 3, -1, 0, 4);
    #1;
    check("t2_bad_ok",   o_frame_ok, 0);
    check("t2_bad_ecnt", ov_err_cnt, 1);
    check("t2_bad_llast", ov_line_last, 32);
    send_frame(32, -1, 4, -1, 0, 4);
    #1;
    check("t2_good_ok",   o_frame_ok, 1);
    check("t2_good_ecnt", ov_err_cnt, 1);
    check("t2_fcnt",      ov_frame_cnt, 5);

    // Pixel 100 corrupted.
`ifdef PATTERN_CHECK_EN
    exp_ok = 1'b0; exp_err = 2;
`else
    exp_ok = 1'b1; exp_err = 1;
`endif
    send_frame(32, -1, 5, 100, 0, 4);
    #1;
    check("t3_ok",   o_frame_ok, 32'(exp_ok));
    check("t3_ecnt", ov_err_cnt, exp_err);
    check("t3_fcnt", ov_frame_cnt, 6);

    // Reset asserted and released in the middle of a frame.
    done_ref = done_seen;
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 8'(6 + i));
    @(negedge clk) reset = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 8'hA5);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 8'(i));
    idle(6);
    #1;
    check("t4_nopulse", done_seen, done_ref);
    check("t4_fcnt0",   ov_frame_cnt, 0);
    send_frame(32, -1, 0, -1, 0, 4);
    #1;
    check("t4_pulse", done_seen, done_ref + 1);
    check("t4_ok",    o_frame_ok, 1);
    check("t4_fcnt",  ov_frame_cnt, 1);
    check("t4_ecnt",  ov_err_cnt, 0);

    // 31-line frame, then an lval pulse outside fval poisons the following frame.
    send_frame(31, -1, 1, -1, 0, 4);
    #1;
    check("t5_ok",    o_frame_ok, 0);
    check("t5_llast", ov_line_last, 31);
    check("t5_ecnt",  ov_err_cnt, 1);
    drive(1'b0, 1'b1, 8'h55);
    idle(3);
    send_frame(32, -1, 2, -1, 0, 4);
    #1;
    check("t5_prot_ok",    o_frame_ok, 0);
    check("t5_prot_ecnt",  ov_err_cnt, 2);
    check("t5_prot_llast", ov_line_last, 32);
    check("t5_fcnt",       ov_frame_cnt, 3);

    // Back-to-back frames with random lval stalls.
    done_ref = done_seen;
    bad_ref  = bad_seen;
    send_frame(32, -1, 3, -1, 2, 1);
    send_frame(32, -1, 4, -1, 2, 1);
    send_frame(32, -1, 5, -1, 2, 4);
    idle(2);
    #1;
    check("t6_done", done_seen - done_ref, 3);
    check("t6_bad",  bad_seen - bad_ref, 0);
    check("t6_ok",   o_frame_ok, 1);
    check("t6_fcnt", ov_frame_cnt, 6);
    check("t6_ecnt", ov_err_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
